// File: rtl/mab_calc.sv
// Effective-address calculator for MSP430 source/destination operands.
// Decodes the addressing mode, fetches the index word when needed and presents a registered result.
module mab_calc #(
  parameter int WIDTH = 16,
  parameter bit CG_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [3:0]       reg_num,
  input  logic             BW,
  input  logic [WIDTH-1:0] reg_val,
  input  logic [WIDTH-1:0] reg_PC_out,
  input  logic [WIDTH-1:0] MDB_out,
  input  logic             mem_rdy,
  input  logic             ack,
  output logic [WIDTH-1:0] CALC_out,
  output logic             CALC_done,
  output logic [1:0]       CALC_kind,
  output logic             CALC_busy,
  output logic             X_fetch,
  output logic             PC_inc,
  output logic             Rn_inc,
  output logic [1:0]       Rn_inc_amt
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ADD, S_DONE} state_t;

  localparam logic [1:0] KIND_MEM   = 2'd0;
  localparam logic [1:0] KIND_REG   = 2'd1;
  localparam logic [1:0] KIND_CONST = 2'd2;

  state_t           state_reg, state_next;
  logic [3:0]       rn_reg, rn_next;
  logic [WIDTH-1:0] rv_reg, rv_next;
  logic [WIDTH-1:0] x_reg, x_next;
  logic [WIDTH-1:0] base_reg, base_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [1:0]       kind_reg, kind_next;
  logic             pc_inc_reg, pc_inc_next;
  logic             rn_inc_reg, rn_inc_next;
  logic [1:0]       amt_reg, amt_next;

  logic             is_cg;
  logic [WIDTH-1:0] cg_val;
  logic             load;

  // Constant generator: R3 in every mode, R2 only in the two indirect modes.
  always_comb begin
    is_cg  = 1'b0;
    cg_val = '0;
    if (CG_EN) begin
      if (reg_num == 4'd3) begin
        is_cg = 1'b1;
        case (mode)
          2'b00:   cg_val = '0;
          2'b01:   cg_val = WIDTH'(1);
          2'b10:   cg_val = WIDTH'(2);
          default: cg_val = '1;
        endcase
      end else if (reg_num == 4'd2 && mode[1]) begin
        is_cg  = 1'b1;
        cg_val = mode[0] ? WIDTH'(8) : WIDTH'(4);
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    rn_next     = rn_reg;
    rv_next     = rv_reg;
    x_next      = x_reg;
    base_next   = base_reg;
    out_next    = out_reg;
    kind_next   = kind_reg;
    amt_next    = amt_reg;
    pc_inc_next = 1'b0;
    rn_inc_next = 1'b0;
    load        = 1'b0;

    case (state_reg)
      S_IDLE: load = start;
      S_FETCH: begin
        if (mem_rdy) begin
          x_next = MDB_out;
          if (CG_EN && rn_reg == 4'd2)
            base_next = '0;
          else if (rn_reg == 4'd0)
            base_next = reg_PC_out;
          else
            base_next = rv_reg;
          pc_inc_next = 1'b1;
          state_next  = S_ADD;
        end
      end
      S_ADD: begin
        out_next   = base_reg + x_reg;
        kind_next  = KIND_MEM;
        state_next = S_DONE;
      end
      S_DONE: begin
        if (ack) begin
          load       = start;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Shared decode so a DONE+ack+start turns straight into the next op.
    if (load) begin
      rn_next  = reg_num;
      rv_next  = reg_val;
      amt_next = (BW && reg_num > 4'd1) ? 2'd1 : 2'd2;
      if (is_cg) begin
        out_next   = cg_val;
        kind_next  = KIND_CONST;
        state_next = S_DONE;
      end else if (mode == 2'b00) begin
        out_next   = reg_val;
        kind_next  = KIND_REG;
        state_next = S_DONE;
      end else if (mode == 2'b01) begin
        state_next = S_FETCH;
      end else begin
        out_next    = reg_val;
        kind_next   = KIND_MEM;
        rn_inc_next = mode[0];
        state_next  = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      rn_reg     <= '0;
      rv_reg     <= '0;
      x_reg      <= '0;
      base_reg   <= '0;
      out_reg    <= '0;
      kind_reg   <= '0;
      amt_reg    <= '0;
      pc_inc_reg <= 1'b0;
      rn_inc_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rn_reg     <= rn_next;
      rv_reg     <= rv_next;
      x_reg      <= x_next;
      base_reg   <= base_next;
      out_reg    <= out_next;
      kind_reg   <= kind_next;
      amt_reg    <= amt_next;
      pc_inc_reg <= pc_inc_next;
      rn_inc_reg <= rn_inc_next;
    end
  end

  assign CALC_out   = out_reg;
  assign CALC_kind  = kind_reg;
  assign CALC_done  = (state_reg == S_DONE);
  assign CALC_busy  = (state_reg != S_IDLE);
  assign X_fetch    = (state_reg == S_FETCH);
  assign PC_inc     = pc_inc_reg;
  assign Rn_inc     = rn_inc_reg;
  assign Rn_inc_amt = amt_reg;

endmodule
